// File: rtl/line_buffer_pkg.sv
// rtl/line_buffer_pkg.sv - shared defaults and width helpers for the line buffer
package line_buffer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // LSB of column slice k in a packed column of pixels dw bits wide
  function automatic int slice_lsb(input int k, input int dw);
    return k * dw;
  endfunction

  function automatic int col_cnt_width(input int line_width);
    return (line_width > 1) ? $clog2(line_width) : 1;
  endfunction

  function automatic int row_cnt_width(input int frame_height);
    return (frame_height > 1) ? $clog2(frame_height) : 1;
  endfunction

endpackage

// File: rtl/line_delay.sv
// rtl/line_delay.sv - one line of pixel delay, read-before-write at a shared pointer
module line_delay #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] ptr_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  output logic [DATA_WIDTH-1:0]    data_o
);

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Contents are never reset; writes are only suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (we_i && rst_n) begin
      ram[ptr_i] <= data_i;
    end
  end

  assign data_o = ram[ptr_i];

endmodule

// File: rtl/fifo_multi_line_buffer.sv
// rtl/fifo_multi_line_buffer.sv - NUM_LINES-high pixel column generator over a line delay chain
module fifo_multi_line_buffer
  import line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int LINE_WIDTH   = 640,
  parameter int NUM_LINES    = 3,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clear_i,
  input  logic                                       we_i,
  input  logic [DATA_WIDTH-1:0]                      data_i,
  output logic [NUM_LINES*DATA_WIDTH-1:0]            data_o,
  output logic                                       valid_o,
  output logic [col_cnt_width(LINE_WIDTH)-1:0]       col_o,
  output logic [row_cnt_width(FRAME_HEIGHT)-1:0]     row_o,
  output logic                                       done_o
);

  localparam int CW = col_cnt_width(LINE_WIDTH);
  localparam int RW = row_cnt_width(FRAME_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [RW-1:0] FILL_ROW = RW'(NUM_LINES - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          accept;
  logic          col_last;
  logic          row_last;

  logic [DATA_WIDTH-1:0]           stage [NUM_LINES];
  logic [NUM_LINES*DATA_WIDTH-1:0] column;

  // A clear in the same cycle drops the pixel, including its RAM write.
  assign accept   = we_i && !clear_i;
  assign col_last = (col_cnt == COL_LAST);
  assign row_last = (row_cnt == ROW_LAST);

  assign stage[0] = data_i;

  genvar k;
  generate
    for (k = 1; k < NUM_LINES; k++) begin : g_line
      line_delay #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LINE_WIDTH)
      ) u_line_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept),
        .ptr_i  (col_cnt),
        .data_i (stage[k-1]),
        .data_o (stage[k])
      );
    end
    for (k = 0; k < NUM_LINES; k++) begin : g_slice
      assign column[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = stage[k];
    end
  endgenerate

  // The column counter doubles as the shared RAM pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      col_o   <= '0;
      row_o   <= '0;
      done_o  <= 1'b0;
    end else if (clear_i) begin
      col_cnt <= '0;
      row_cnt <= '0;
      valid_o <= 1'b0;
      done_o  <= 1'b0;
    end else if (we_i) begin
      data_o  <= column;
      col_o   <= col_cnt;
      row_o   <= row_cnt;
      valid_o <= (row_cnt >= FILL_ROW);
      done_o  <= col_last && row_last;
      col_cnt <= col_last ? '0 : col_cnt + 1'b1;
      if (col_last) begin
        row_cnt <= row_last ? '0 : row_cnt + 1'b1;
      end
    end else begin
      valid_o <= 1'b0;
      done_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_multi_line_buffer.sv
// tb/tb_fifo_multi_line_buffer.sv - directed checks of the multi-line column generator
module tb_fifo_multi_line_buffer;

  localparam int DW1 = 8,  LW1 = 5, NL1 = 3, FH1 = 4;
  localparam int DW2 = 10, LW2 = 7, NL2 = 5, FH2 = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic                 clr1 = 1'b0, we1 = 1'b0;
  logic [DW1-1:0]       d1 = '0;
  logic [NL1*DW1-1:0]   q1;
  logic                 v1, dn1;
  logic [2:0]           c1;
  logic [1:0]           r1;

  logic                 clr2 = 1'b0, we2 = 1'b0;
  logic [DW2-1:0]       d2 = '0;
  logic [NL2*DW2-1:0]   q2;
  logic                 v2, dn2;
  logic [2:0]           c2;
  logic [2:0]           r2;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  fifo_multi_line_buffer #(
    .DATA_WIDTH(DW1), .LINE_WIDTH(LW1), .NUM_LINES(NL1), .FRAME_HEIGHT(FH1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .clear_i(clr1), .we_i(we1), .data_i(d1),
    .data_o(q1), .valid_o(v1), .col_o(c1), .row_o(r1), .done_o(dn1)
  );

  fifo_multi_line_buffer #(
    .DATA_WIDTH(DW2), .LINE_WIDTH(LW2), .NUM_LINES(NL2), .FRAME_HEIGHT(FH2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .clear_i(clr2), .we_i(we2), .data_i(d2),
    .data_o(q2), .valid_o(v2), .col_o(c2), .row_o(r2), .done_o(dn2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel value v with the pixels k lines above it equal to v - k*lw.
  function automatic logic [63:0] col_exp(input int v, input int nl, input int lw, input int dw);
    logic [63:0] e = '0;
    logic [63:0] m = (64'd1 << dw) - 64'd1;
    for (int k = 0; k < nl; k++) e |= ((64'(v - k * lw)) & m) << (k * dw);
    return e;
  endfunction

  task automatic push1(input int v, input int p);
    int r, c;
    logic vld, dn;
    r = (p / LW1) % FH1;
    c = p % LW1;
    vld = (r >= NL1 - 1);
    dn = (r == FH1 - 1) && (c == LW1 - 1);
    @(negedge clk);
    we1 = 1'b1;
    d1 = DW1'(v);
    @(posedge clk);
    #1;
    we1 = 1'b0;
    check_eq($sformatf("d1_valid_p%0d", v), 64'(v1), 64'(vld));
    check_eq($sformatf("d1_col_p%0d", v), 64'(c1), 64'(c));
    check_eq($sformatf("d1_row_p%0d", v), 64'(r1), 64'(r));
    check_eq($sformatf("d1_done_p%0d", v), 64'(dn1), 64'(dn));
    if (vld) check_eq($sformatf("d1_column_p%0d", v), 64'(q1), col_exp(v, NL1, LW1, DW1));
  endtask

  task automatic idle1(input int n, input int v, input int c, input int r);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      we1 = 1'b0;
      @(posedge clk);
      #1;
      check_eq("d1_gap_valid", 64'(v1), 64'd0);
      check_eq("d1_gap_done", 64'(dn1), 64'd0);
      check_eq("d1_gap_column", 64'(q1), col_exp(v, NL1, LW1, DW1));
      check_eq("d1_gap_col", 64'(c1), 64'(c));
      check_eq("d1_gap_row", 64'(r1), 64'(r));
    end
  endtask

  task automatic push2(input int v);
    int r, c;
    logic vld, dn;
    r = (v / LW2) % FH2;
    c = v % LW2;
    vld = (r >= NL2 - 1);
    dn = (r == FH2 - 1) && (c == LW2 - 1);
    @(negedge clk);
    we2 = 1'b1;
    d2 = DW2'(v);
    @(posedge clk);
    #1;
    we2 = 1'b0;
    check_eq($sformatf("d2_valid_p%0d", v), 64'(v2), 64'(vld));
    check_eq($sformatf("d2_col_p%0d", v), 64'(c2), 64'(c));
    check_eq($sformatf("d2_row_p%0d", v), 64'(r2), 64'(r));
    check_eq($sformatf("d2_done_p%0d", v), 64'(dn2), 64'(dn));
    if (vld) check_eq($sformatf("d2_column_p%0d", v), 64'(q2), col_exp(v, NL2, LW2, DW2));
  endtask

  task automatic check_reset1(input string tag);
    check_eq({tag, "_data"}, 64'(q1), 64'd0);
    check_eq({tag, "_valid"}, 64'(v1), 64'd0);
    check_eq({tag, "_col"}, 64'(c1), 64'd0);
    check_eq({tag, "_row"}, 64'(r1), 64'd0);
    check_eq({tag, "_done"}, 64'(dn1), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset1("por");
    check_eq("por_d2_valid", 64'(v2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame, continuous stream
    for (int i = 0; i < 20; i++) push1(i, i);
    idle1(1, 19, 4, 3);

    // Three-cycle gap after pixel 12
    for (int i = 0; i < 13; i++) push1(i, i);
    idle1(3, 12, 2, 2);
    for (int i = 13; i < 20; i++) push1(i, i);

    // Two frames back to back; frame 2 must refill before valid
    for (int i = 0; i < 40; i++) push1(i, i);

    // Mid-frame reset, then restream from scratch
    for (int i = 0; i < 12; i++) push1(i, i);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset1("async_rst");
    @(posedge clk);
    #1;
    check_reset1("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) push1(i, i);

    // Clear coinciding with pixel 7 drops it and restarts counters
    for (int i = 0; i < 7; i++) push1(i, i);
    @(negedge clk);
    we1 = 1'b1;
    clr1 = 1'b1;
    d1 = 8'd7;
    @(posedge clk);
    #1;
    we1 = 1'b0;
    clr1 = 1'b0;
    check_eq("clr_valid", 64'(v1), 64'd0);
    check_eq("clr_done", 64'(dn1), 64'd0);
    push1(8, 0);

    // Wider configuration on the second instance
    for (int i = 0; i < 42; i++) push2(i);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_multi_line_buffer.md
# fifo_multi_line_buffer

Parametrised line-buffer window generator for the streaming edge-detection pipeline. It accepts one pixel per enabled cycle and presents a vertical column of `NUM_LINES` pixels: the current pixel plus the pixels at the same column in the previous `NUM_LINES-1` lines. The column feeds the kernel window stage (for example a 3x3 Sobel). Compared with the fixed two-line buffer, it generalises data width, line length and line count, and adds column/row tracking, fill-qualified valid, frame-end done and synchronous clear.

## Interface
- `DATA_WIDTH`, default 8: pixel width in bits.
- `LINE_WIDTH`, default 640: pixels per line; delay depth of each line stage; ≥ 2.
- `NUM_LINES`, default 3: column height produced; ≥ 2.
- `FRAME_HEIGHT`, default 480: lines per frame; ≥ `NUM_LINES`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clear_i`  in  1: synchronous clear of counters and fill state; has priority over `we_i`.
- `we_i`  in  1: pixel strobe; `data_i` is accepted on a rising edge when high.
- `data_i`  in  `DATA_WIDTH`: input pixel, raster order.
- `data_o`  out  `NUM_LINES*DATA_WIDTH`: column; slice k (`[k*DATA_WIDTH +: DATA_WIDTH]`) is the pixel k lines above the current one; k=0 is the current pixel.
- `valid_o`  out  1: `data_o` holds a fully populated column.
- `col_o`  out  `$clog2(LINE_WIDTH)`: column index of the pixel on `data_o`.
- `row_o`  out  `$clog2(FRAME_HEIGHT)`: row index of the pixel on `data_o`.
- `done_o`  out  1: one-cycle pulse with the last pixel of a frame.

## Operation
- Chain of `NUM_LINES-1` line delays, each `LINE_WIDTH` deep. Stage k input is stage k-1 output; stage 1 input is `data_i`.
- On `we_i`: each stage does read-before-write at the shared write pointer. Column slice 0 = `data_i`; slice k = output of stage k.
- Pointer and column counter wrap from `LINE_WIDTH-1` to 0. Row counter increments on column wrap and wraps from `FRAME_HEIGHT-1` to 0.
- Fill: `valid_o` is qualified only when the row of the accepted pixel is ≥ `NUM_LINES-1`. Rows above the fill point produce `valid_o`=0, never stale data marked valid.
- `done_o` = accepted pixel at (row `FRAME_HEIGHT-1`, col `LINE_WIDTH-1`). The next frame restarts at row 0, col 0 and refills.
- When `we_i`=0: pointers, counters and RAM hold. `data_o`, `col_o` and `row_o` hold. `valid_o`=0 and `done_o`=0.
- `clear_i`: counters, pointer, `valid_o` and `done_o` go to 0. RAM is not cleared; fill gating hides its contents.
- `clear_i` and `we_i` high together: the clear wins and the pixel is dropped.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, `col_o`=0, `row_o`=0, `done_o`=0. Internal pointer, row counter and column counter are 0. RAM is not reset.
- Latency: one cycle. Outputs registered on the edge that accepts the pixel, visible during the following cycle.
- Throughput: one pixel per cycle; back-to-back `we_i` is supported with no bubbles.
- `rst_n` asserted mid-frame: outputs drop immediately. After release the block behaves as after power-up and the first accepted pixel is row 0, col 0.
- Width: counters use `$clog2` widths. Wrap is an explicit compare against `LINE_WIDTH-1` and `FRAME_HEIGHT-1`, so non-power-of-two sizes are correct.

## Structure
- Shared package `line_buffer_pkg`:
  - default `DATA_WIDTH`;
  - column-slice index helper;
  - `localparam` width functions for column and row counters.
- Sub-module `line_delay`:
  - parameters `DATA_WIDTH`, `DEPTH`;
  - inputs `clk`, `rst_n`, `we_i`, `ptr_i`, `data_i`; output `data_o`;
  - inferred RAM, read-before-write, combinational output at `ptr_i`;
  - instantiated `NUM_LINES-1` times in a generate loop, sharing one pointer.
- Top keeps the counters, fill/valid/done logic and the output registers.

## Test plan
Default bench configuration: `LINE_WIDTH`=5, `NUM_LINES`=3, `FRAME_HEIGHT`=4; inputs are pixel i = i.
- Reset, then stream i=0..19 continuously. Required response:
  - `valid_o` is first high the cycle after pixel 10, with column {row2=0, row1=5, row0=10}, `col_o`=0, `row_o`=2;
  - pixel 19 gives {9, 14, 19} and `done_o`=1 for exactly one cycle.
- Same stream with `we_i` low for 3 cycles after pixel 12 → `valid_o`=0 during the gap, outputs hold; pixel 13 then gives {3, 8, 13}.
- Two frames back-to-back (i=0..39):
  - `valid_o`=0 for frame-2 rows 0–1;
  - frame-2 pixel (row 2, col 0) = 30 gives {20, 25, 30};
  - `done_o` pulses after pixel 19 and after pixel 39.
- Assert `rst_n` low after pixel 11, then restream i=0..19 → all outputs 0 during reset; response identical to the first scenario.
- `clear_i` with `we_i` at pixel 7 → pixel dropped and counters 0; the next pixel is reported as `col_o`=0, `row_o`=0, `valid_o`=0.
- Re-run the first scenario with `DATA_WIDTH`=10, `NUM_LINES`=5, `LINE_WIDTH`=7, `FRAME_HEIGHT`=6:
  - first valid after pixel 28 with column {0, 7, 14, 21, 28};
  - `done_o` after pixel 41.
